// File: rtl/eva_ahb_slv_mem.sv
// AHB-Lite word-addressed memory slave with programmable wait states.
// Illegal size, misaligned or out-of-range accesses get a two-cycle ERROR response.
module eva_ahb_slv_mem #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned AW          = 32
) (
  input  logic          hclk,
  input  logic          hrest_n,
  input  logic          hsel,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [AW-1:0] haddr,
  input  logic [31:0]   hwdata,
  input  logic [1:0]    hsize,
  input  logic [2:0]    hburst,
  input  logic [3:0]    hprot,
  input  logic          hready_in,
  output logic          hready_out,
  output logic [1:0]    hresp,
  output logic [31:0]   hrdata
);

  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [2:0] {StIdle, StWait, StDone, StErr1, StErr2} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          write_q, write_d;
  logic [31:0]   mem_q [DEPTH];

  logic          accept;
  logic          addr_err;
  logic [AW-1:0] addr_hi;
  logic          unused_ctrl;

  assign unused_ctrl = ^{hburst, hprot};

  assign accept   = hsel & htrans[1] & hready_in;
  // Bits above the decoded index must be zero so out-of-range never aliases.
  assign addr_hi  = haddr >> (IW + 2);
  assign addr_err = (hsize != 2'b10) | (haddr[1:0] != 2'b00) | (addr_hi != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    case (state_q)
      StWait: begin
        if (cnt_q == 4'd0) state_d = StDone;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StErr1: state_d = StErr2;
      default: begin
        // IDLE, DONE and ERR2 all leave hready_out high, so each may take a new beat.
        state_d = StIdle;
        if (accept) begin
          idx_d   = haddr[IW+1:2];
          write_d = hwrite;
          if (addr_err) begin
            state_d = StErr1;
          end else if (WAIT_STATES == 0) begin
            state_d = StDone;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hrest_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
    end
  end

  // Write commits at the edge closing the DONE cycle; reset discards it.
  always_ff @(posedge hclk) begin
    if (hrest_n && (state_q == StDone) && write_q) begin
      mem_q[idx_q] <= hwdata;
    end
  end

  assign hready_out = !((state_q == StWait) || (state_q == StErr1));
  assign hresp      = ((state_q == StErr1) || (state_q == StErr2)) ? 2'b01 : 2'b00;
  assign hrdata     = ((state_q == StDone) && !write_q) ? mem_q[idx_q] : 32'h0;

endmodule

// File: tb/tb_eva_ahb_slv_mem.sv
// Directed bench: three slaves (0, 3 and 2 wait states) share one bus, selected one at a time.
module tb_eva_ahb_slv_mem;

  logic        hclk = 1'b0;
  logic        hrest_n;
  logic        sel0, sel3, sel2;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;

  logic        rdy0, rdy3, rdy2;
  logic [1:0]  resp0, resp3, resp2;
  logic [31:0] rd0, rd3, rd2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 hclk = ~hclk;

  eva_ahb_slv_mem #(.DEPTH(256), .WAIT_STATES(0), .AW(32)) u_ws0 (
    .hclk(hclk), .hrest_n(hrest_n), .hsel(sel0), .htrans(htrans), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hready_in(rdy0), .hready_out(rdy0), .hresp(resp0), .hrdata(rd0)
  );

  eva_ahb_slv_mem #(.DEPTH(256), .WAIT_STATES(3), .AW(32)) u_ws3 (
    .hclk(hclk), .hrest_n(hrest_n), .hsel(sel3), .htrans(htrans), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hready_in(rdy3), .hready_out(rdy3), .hresp(resp3), .hrdata(rd3)
  );

  eva_ahb_slv_mem #(.DEPTH(256), .WAIT_STATES(2), .AW(32)) u_ws2 (
    .hclk(hclk), .hrest_n(hrest_n), .hsel(sel2), .htrans(htrans), .hwrite(hwrite),
    .haddr(haddr), .hwdata(hwdata), .hsize(hsize), .hburst(hburst), .hprot(hprot),
    .hready_in(rdy2), .hready_out(rdy2), .hresp(resp2), .hrdata(rd2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge hclk);
  endtask

  task automatic addr_phase(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                            input logic [1:0] sz);
    htrans = tr;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  task automatic bus_idle();
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr  = 32'h0;
    hsize  = 2'b10;
  endtask

  initial begin
    hrest_n = 1'b0;
    {sel0, sel3, sel2} = 3'b000;
    bus_idle();
    hwdata = 32'h0;
    hburst = 3'b000;
    hprot  = 4'b0011;
    step();
    step();
    hrest_n = 1'b1;
    at_neg();
    chk("rst_rdy0", 32'(rdy0), 32'd1);
    chk("rst_resp0", 32'(resp0), 32'd0);
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_rdy3", 32'(rdy3), 32'd1);
    chk("rst_rd2", rd2, 32'h0);
    step();

    // Zero-wait write then back-to-back read of 0x10.
    sel0 = 1'b1;
    addr_phase(2'b10, 1'b1, 32'h10, 2'b10);
    at_neg();
    chk("ws0_wr_addr_rdy", 32'(rdy0), 32'd1);
    step();
    hwdata = 32'hDEADBEEF;
    addr_phase(2'b10, 1'b0, 32'h10, 2'b10);
    at_neg();
    chk("ws0_wr_data_rdy", 32'(rdy0), 32'd1);
    chk("ws0_wr_data_rd", rd0, 32'h0);
    step();
    bus_idle();
    at_neg();
    chk("ws0_rd_rdy", 32'(rdy0), 32'd1);
    chk("ws0_rd_resp", 32'(resp0), 32'd0);
    chk("ws0_rd_data", rd0, 32'hDEADBEEF);
    step();
    at_neg();
    chk("ws0_idle_rd", rd0, 32'h0);
    sel0 = 1'b0;

    // Three wait states: write 0x12345678 @0, then read @0 issued in the write's DONE cycle.
    sel3 = 1'b1;
    addr_phase(2'b10, 1'b1, 32'h0, 2'b10);
    hwdata = 32'h12345678;
    step();
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk($sformatf("ws3_wr_wait%0d", i), 32'(rdy3), 32'd0);
      step();
    end
    addr_phase(2'b10, 1'b0, 32'h0, 2'b10);
    at_neg();
    chk("ws3_wr_done_rdy", 32'(rdy3), 32'd1);
    step();
    bus_idle();
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk($sformatf("ws3_rd_wait%0d", i), 32'(rdy3), 32'd0);
      chk($sformatf("ws3_rd_wait_data%0d", i), rd3, 32'h0);
      step();
    end
    at_neg();
    chk("ws3_rd_rdy", 32'(rdy3), 32'd1);
    chk("ws3_rd_resp", 32'(resp3), 32'd0);
    chk("ws3_rd_data", rd3, 32'h12345678);
    step();
    sel3 = 1'b0;

    // Out-of-range write @0x400 must error and must not alias onto word 0.
    sel0 = 1'b1;
    addr_phase(2'b10, 1'b1, 32'h0, 2'b10);
    step();
    hwdata = 32'hA5A5A5A5;
    addr_phase(2'b10, 1'b1, 32'h400, 2'b10);
    step();
    bus_idle();
    hwdata = 32'hFFFFFFFF;
    at_neg();
    chk("oor_err1_rdy", 32'(rdy0), 32'd0);
    chk("oor_err1_resp", 32'(resp0), 32'd1);
    step();
    addr_phase(2'b10, 1'b0, 32'h0, 2'b10);
    at_neg();
    chk("oor_err2_rdy", 32'(rdy0), 32'd1);
    chk("oor_err2_resp", 32'(resp0), 32'd1);
    chk("oor_err2_rd", rd0, 32'h0);
    step();
    bus_idle();
    at_neg();
    chk("oor_rd_resp", 32'(resp0), 32'd0);
    chk("oor_rd_data", rd0, 32'hA5A5A5A5);
    step();

    // Halfword size, then misaligned address, each issued from the previous ERR2.
    addr_phase(2'b10, 1'b1, 32'h0, 2'b01);
    step();
    bus_idle();
    at_neg();
    chk("hsize_err1_rdy", 32'(rdy0), 32'd0);
    chk("hsize_err1_resp", 32'(resp0), 32'd1);
    step();
    addr_phase(2'b10, 1'b0, 32'h6, 2'b10);
    at_neg();
    chk("hsize_err2_resp", 32'(resp0), 32'd1);
    step();
    bus_idle();
    at_neg();
    chk("mis_err1_rdy", 32'(rdy0), 32'd0);
    chk("mis_err1_resp", 32'(resp0), 32'd1);
    step();
    addr_phase(2'b10, 1'b0, 32'h10, 2'b10);
    at_neg();
    chk("mis_err2_rdy", 32'(rdy0), 32'd1);
    chk("mis_err2_resp", 32'(resp0), 32'd1);
    step();
    bus_idle();
    at_neg();
    chk("after_err_rdy", 32'(rdy0), 32'd1);
    chk("after_err_resp", 32'(resp0), 32'd0);
    chk("after_err_data", rd0, 32'hDEADBEEF);
    step();

    // BUSY and IDLE while selected, NONSEQ while deselected: no transfer, no write.
    hwdata = 32'h0BAD0BAD;
    addr_phase(2'b01, 1'b1, 32'h10, 2'b10);
    step();
    at_neg();
    chk("busy_rdy", 32'(rdy0), 32'd1);
    chk("busy_resp", 32'(resp0), 32'd0);
    chk("busy_rd", rd0, 32'h0);
    addr_phase(2'b00, 1'b1, 32'h10, 2'b10);
    step();
    at_neg();
    chk("idle_rdy", 32'(rdy0), 32'd1);
    chk("idle_resp", 32'(resp0), 32'd0);
    sel0 = 1'b0;
    addr_phase(2'b10, 1'b1, 32'h10, 2'b10);
    step();
    at_neg();
    chk("nosel_rdy", 32'(rdy0), 32'd1);
    chk("nosel_resp", 32'(resp0), 32'd0);
    chk("nosel_rd", rd0, 32'h0);
    step();
    sel0 = 1'b1;
    addr_phase(2'b10, 1'b0, 32'h10, 2'b10);
    step();
    bus_idle();
    at_neg();
    chk("nochg_data", rd0, 32'hDEADBEEF);
    step();
    sel0 = 1'b0;

    // Two wait states: seed @0x20, then reset during the WAIT of an overwrite.
    sel2 = 1'b1;
    addr_phase(2'b10, 1'b1, 32'h20, 2'b10);
    hwdata = 32'h11111111;
    step();
    bus_idle();
    step();
    step();
    at_neg();
    chk("ws2_seed_done_rdy", 32'(rdy2), 32'd1);
    step();
    addr_phase(2'b10, 1'b1, 32'h20, 2'b10);
    hwdata = 32'h22222222;
    step();
    bus_idle();
    at_neg();
    chk("ws2_wait_rdy", 32'(rdy2), 32'd0);
    hrest_n = 1'b0;
    step();
    hrest_n = 1'b1;
    at_neg();
    chk("ws2_rst_rdy", 32'(rdy2), 32'd1);
    chk("ws2_rst_resp", 32'(resp2), 32'd0);
    step();
    at_neg();
    chk("ws2_rst_idle_rdy", 32'(rdy2), 32'd1);
    step();
    step();
    addr_phase(2'b10, 1'b0, 32'h20, 2'b10);
    step();
    bus_idle();
    at_neg();
    chk("ws2_rd_wait0", 32'(rdy2), 32'd0);
    step();
    at_neg();
    chk("ws2_rd_wait1", 32'(rdy2), 32'd0);
    step();
    at_neg();
    chk("ws2_rd_rdy", 32'(rdy2), 32'd1);
    chk("ws2_rd_data", rd2, 32'h11111111);
    step();
    sel2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
